result_capture_buffer: RTL and testbench

Parametrised capture buffer between the vector processor's result/data output and the frame writeback path. It latches every `in_data` word qualified by `in_valid` into a FIFO, up to a programmed word count. The words drain through a valid/ready port. Status (captured count, overflow, done) is reported for the host and the bench. It replaces ad-hoc enable-qualified sampling with a bounded, back-pressured, checkable capture.

---
 rtl/result_capture_buffer.sv | 191 +++++++++++++++++++
 tb/tb_result_capture_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_capture_buffer.sv
// ---------------------------------------------------------------------------
// result_capture_buffer
//
// Purpose:
//   Bounded capture buffer between the vector processor's result output and
//   the frame writeback path. Each in_data word that arrives with in_valid
//   during a capture run is pushed into a first-word-fall-through FIFO. The
//   run ends after a programmed number of words. The words drain through a
//   valid/ready port. Status outputs give the captured count, sticky
//   overflow, busy and done.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      one-cycle pulse that arms a run (honoured in IDLE/DONE only)
//   abort      ends a busy run, flushes the FIFO, keeps captured/overflow
//   limit      number of words to capture, sampled on an accepted start
//   in_valid   processor word qualifier
//   in_data    processor word
//   out_valid  FIFO holds at least one word
//   out_ready  downstream accepts the head word
//   out_data   FIFO head word, forced to zero while the FIFO is empty
//   captured   words pushed in the current run
//   level      FIFO occupancy
//   busy       run in progress (CAPTURE or DRAIN)
//   done       run complete and FIFO drained
//   overflow   sticky: a valid word was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module result_capture_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         limit,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CNT_W-1:0]         captured,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [LVL_W-1:0]    r_level;
    logic [CNT_W-1:0]    r_captured;
    logic [CNT_W-1:0]    r_limit;
    logic                r_overflow;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_busy;
    logic                w_empty;
    logic                w_full;
    logic                w_abort;
    logic                w_start;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic                w_lastPush;

    assign w_busy  = (r_state == S_CAPTURE) || (r_state == S_DRAIN);
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LEVEL);

    // abort only acts on a busy run; start only acts when idle or done.
    // Since these are mutually exclusive, "abort wins if busy" falls out.
    assign w_abort = abort && w_busy;
    assign w_start = start && !w_busy;

    // Full is judged on the registered level, so a pop in the same cycle
    // never makes room for a push.
    assign w_push = (r_state == S_CAPTURE) && in_valid && !w_full && !w_abort;
    assign w_drop = (r_state == S_CAPTURE) && in_valid &&  w_full && !w_abort;
    assign w_pop  = !w_empty && out_ready && !w_abort;

    assign w_lastPush = ((r_captured + CNT_W'(1)) == r_limit);

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_nextState = (limit != '0) ? S_CAPTURE : S_DONE;
                end
            end
            S_CAPTURE: begin
                if (w_abort) begin
                    w_nextState = S_IDLE;
                end else if (w_push && w_lastPush) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Uses the registered level, so done rises one edge after
                // the final pop empties the FIFO.
                if (w_abort) begin
                    w_nextState = S_IDLE;
                end else if (w_empty) begin
                    w_nextState = S_DONE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // State, FIFO pointers, occupancy and run status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_captured <= '0;
            r_limit    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (w_abort) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_level <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_W'(1);
                    2'b01:   r_level <= r_level - LVL_W'(1);
                    default: r_level <= r_level;
                endcase
            end

            if (w_start) begin
                r_limit    <= limit;
                r_captured <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_captured <= r_captured + CNT_W'(1);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // FIFO storage. It has no reset because out_data is masked while the
    // FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rdPtr];
    assign captured  = r_captured;
    assign level     = r_level;
    assign busy      = w_busy;
    assign done      = (r_state == S_DONE);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_result_capture_buffer.sv
// Directed bench for result_capture_buffer. The stimulus pushes every word
// it expects the buffer to accept onto expQ. A separate monitor pops expQ
// on each output handshake and compares the popped word with out_data.
module tb_result_capture_buffer;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 24;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  limit;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  captured;
    logic [LVL_W-1:0]  level;
    logic              busy;
    logic              done;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] expQ[$];

    result_capture_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .limit    (limit),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .captured (captured),
        .level    (level),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    // 10 ns clock: rising edges at 5, 15, 25 and so on.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge. Inputs are driven and
    // status outputs are sampled at that point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic rdy, input logic accept);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        if (v && accept) expQ.push_back(d);
        tick();
    endtask

    task automatic startRun(input logic [CNT_W-1:0] lim);
        start = 1'b1;
        limit = lim;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, {63'd0, done}, 64'd1);
    endtask

    // Scoreboard monitor: samples on the falling edge, halfway between
    // rising edges, and counts a handshake when out_valid and out_ready are
    // both high.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL out_data unexpected: got 0x%0h, expected no word", out_data);
            end else begin
                checkOutput("out_data", out_data, expQ.pop_front());
            end
        end
    end

    initial begin
        int maxLevel;
        int sent;
        int k;

        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        limit = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #2;
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_captured", 64'(captured), 64'd0);
        checkOutput("rst_level", 64'(level), 64'd0);
        checkOutput("rst_busy_done_ovf", {61'd0, busy, done, overflow}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] basic run, limit 4");
        out_ready = 1'b1;
        startRun(24'd4);
        checkOutput("basic_busy", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 64'(i), 1'b1, 1'b1);
        in_valid = 1'b0;
        checkOutput("basic_captured", 64'(captured), 64'd4);
        checkOutput("basic_overflow", {63'd0, overflow}, 64'd0);
        tick();
        checkOutput("basic_done_early", {63'd0, done}, 64'd0);
        tick();
        checkOutput("basic_done", {63'd0, done}, 64'd1);
        checkOutput("basic_q_empty", 64'(expQ.size()), 64'd0);

        $display("[TB] minimum latency, limit 1");
        startRun(24'd1);
        applyStimulus(1'b1, 64'hAB, 1'b1, 1'b1);
        in_valid = 1'b0;
        checkOutput("minlat_level_after_push", 64'(level), 64'd1);
        tick();
        checkOutput("minlat_done_after_pop", {63'd0, done}, 64'd0);
        tick();
        checkOutput("minlat_done", {63'd0, done}, 64'd1);

        $display("[TB] backpressure, limit 20");
        out_ready = 1'b0;
        startRun(24'd20);
        for (int i = 1; i <= 20; i++) applyStimulus(1'b1, 64'h100 + 64'(i), 1'b0, i <= 16);
        in_valid = 1'b0;
        checkOutput("bp_level_full", 64'(level), 64'd16);
        checkOutput("bp_overflow", {63'd0, overflow}, 64'd1);
        checkOutput("bp_captured", 64'(captured), 64'd16);
        checkOutput("bp_busy_done", {62'd0, busy, done}, 64'd2);
        checkOutput("bp_head_stable", out_data, 64'h101);
        // One pop-only cycle makes room before the next word is offered.
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 64'h200 + 64'(i), 1'b1, 1'b1);
        in_valid = 1'b0;
        checkOutput("bp_captured_final", 64'(captured), 64'd20);
        waitDone("bp_done", 40);
        checkOutput("bp_overflow_sticky", {63'd0, overflow}, 64'd1);
        checkOutput("bp_q_empty", 64'(expQ.size()), 64'd0);

        $display("[TB] wrap-around, limit 40");
        startRun(24'd40);
        checkOutput("wrap_overflow_cleared", {63'd0, overflow}, 64'd0);
        maxLevel = 0;
        sent = 0;
        k = 0;
        while (sent < 40 && k < 200) begin
            if ((k % 3) != 2) begin
                applyStimulus(1'b1, 64'h1000 + 64'(sent), k[0], 1'b1);
                sent++;
            end else begin
                applyStimulus(1'b0, 64'd0, k[0], 1'b0);
            end
            if (int'(level) > maxLevel) maxLevel = int'(level);
            k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checkOutput("wrap_max_level_ok", {63'd0, (maxLevel <= 16)}, 64'd1);
        checkOutput("wrap_captured", 64'(captured), 64'd40);
        waitDone("wrap_done", 40);
        checkOutput("wrap_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("wrap_q_empty", 64'(expQ.size()), 64'd0);

        $display("[TB] limit 0");
        startRun(24'd0);
        checkOutput("lim0_done", {63'd0, done}, 64'd1);
        checkOutput("lim0_captured", 64'(captured), 64'd0);
        tick();
        tick();
        checkOutput("lim0_out_valid", {63'd0, out_valid}, 64'd0);

        $display("[TB] abort in capture");
        out_ready = 1'b0;
        startRun(24'd10);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 64'h300 + 64'(i), 1'b0, 1'b1);
        in_valid = 1'b0;
        checkOutput("abort_pre_level", 64'(level), 64'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expQ.delete();
        checkOutput("abort_level", 64'(level), 64'd0);
        checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("abort_captured", 64'(captured), 64'd5);
        checkOutput("abort_busy_done", {62'd0, busy, done}, 64'd0);
        startRun(24'd3);
        checkOutput("abort_restart_captured", 64'(captured), 64'd0);
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 64'h400 + 64'(i), 1'b1, 1'b1);
        in_valid = 1'b0;
        waitDone("abort_restart_done", 20);

        $display("[TB] reset mid-run");
        out_ready = 1'b0;
        startRun(24'd10);
        for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 64'h500 + 64'(i), 1'b0, 1'b1);
        in_valid = 1'b0;
        checkOutput("midrst_pre_level", 64'(level), 64'd7);
        #1;
        rst = 1'b0;
        #1;
        expQ.delete();
        checkOutput("midrst_level", 64'(level), 64'd0);
        checkOutput("midrst_captured", 64'(captured), 64'd0);
        checkOutput("midrst_out", {out_data[61:0], out_valid, busy}, 64'd0);
        checkOutput("midrst_done_ovf", {62'd0, done, overflow}, 64'd0);
        #1;
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        startRun(24'd2);
        for (int i = 1; i <= 2; i++) applyStimulus(1'b1, 64'h600 + 64'(i), 1'b1, 1'b1);
        in_valid = 1'b0;
        checkOutput("midrst_after_captured", 64'(captured), 64'd2);
        waitDone("midrst_after_done", 20);
        checkOutput("final_q_empty", 64'(expQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
